vfp_config_sequencer: RTL and testbench



---
 rtl/vfp_config_sequencer.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_vfp_config_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vfp_config_sequencer.sv
// vfp_config_sequencer: AXI4-Lite master that replays a table of
// address/data pairs into the VFP configuration space, with optional
// read-back compare of every entry and a per-phase timeout.
//
// Handshake rule on every channel: a transfer happens on a rising clock edge
// where valid and ready are both high. A valid, once raised, stays high with
// stable payload until its ready is seen; the only exceptions are a timeout
// abort and reset. The sequencer keeps bready/rready high for the whole
// response wait.
module vfp_config_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int TIMEOUT    = 255,
  localparam int IW = $clog2(DEPTH),
  localparam int TW = $clog2(TIMEOUT + 1),
  localparam int SW = DATA_WIDTH / 8
) (
  input  logic                  vfpconfig_aclk,
  input  logic                  vfpconfig_aresetn,
  input  logic                  start,
  input  logic                  verify_en,
  input  logic [IW:0]           num_entries,
  input  logic                  tbl_we,
  input  logic [IW-1:0]         tbl_index,
  input  logic [ADDR_WIDTH-1:0] tbl_addr,
  input  logic [DATA_WIDTH-1:0] tbl_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [IW-1:0]         err_index,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [SW-1:0]         wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [2:0]            dbg_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WR     = 3'd1;
  localparam logic [2:0] S_WAIT_B = 3'd2;
  localparam logic [2:0] S_RD     = 3'd3;
  localparam logic [2:0] S_WAIT_R = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  logic [ADDR_WIDTH-1:0] tbl_a [DEPTH];
  logic [DATA_WIDTH-1:0] tbl_d [DEPTH];

  logic [2:0]            state;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_nxt;
  logic [IW:0]           num_lat;
  logic                  verify_lat;
  logic [TW-1:0]         cnt;
  logic                  tmo;
  logic                  aw_ok;
  logic                  w_ok;
  logic                  row0_byp;
  logic [ADDR_WIDTH-1:0] row0_a;
  logic [DATA_WIDTH-1:0] row0_d;
  logic                  fail_now;
  logic [1:0]            fail_code;

  assign awprot    = 3'b000;
  assign arprot    = 3'b000;
  assign wstrb     = '1;
  assign dbg_state = state;

  // In WR a channel is complete once its valid has dropped or is handshaking now.
  assign aw_ok   = !awvalid || awready;
  assign w_ok    = !wvalid || wready;
  assign tmo     = (cnt == TMAX);
  assign idx_nxt = idx + 1'b1;

  // A table write to row 0 in the start cycle must be seen by entry 0.
  assign row0_byp = tbl_we && !busy && (tbl_index == '0);
  assign row0_a   = row0_byp ? tbl_addr : tbl_a[0];
  assign row0_d   = row0_byp ? tbl_data : tbl_d[0];

  // Table storage: plain registers, deliberately not reset.
  always_ff @(posedge vfpconfig_aclk) begin
    if (tbl_we && !busy) begin
      tbl_a[tbl_index] <= tbl_addr;
      tbl_d[tbl_index] <= tbl_data;
    end
  end

  // Failure detection: bad response, read-back mismatch, or phase timeout.
  always_comb begin
    fail_now  = 1'b0;
    fail_code = 2'b00;
    case (state)
      S_WR: begin
        if (!(aw_ok && w_ok) && tmo) begin
          fail_now  = 1'b1;
          fail_code = 2'b11;
        end
      end
      S_WAIT_B: begin
        if (bvalid) begin
          if (bresp != 2'b00) begin
            fail_now  = 1'b1;
            fail_code = 2'b01;
          end
        end else if (tmo) begin
          fail_now  = 1'b1;
          fail_code = 2'b11;
        end
      end
      S_RD: begin
        if (!arready && tmo) begin
          fail_now  = 1'b1;
          fail_code = 2'b11;
        end
      end
      S_WAIT_R: begin
        if (rvalid) begin
          if (rresp != 2'b00) begin
            fail_now  = 1'b1;
            fail_code = 2'b01;
          end else if (rdata != tbl_d[idx]) begin
            fail_now  = 1'b1;
            fail_code = 2'b10;
          end
        end else if (tmo) begin
          fail_now  = 1'b1;
          fail_code = 2'b11;
        end
      end
      default: ;
    endcase
  end

  // Sequencer FSM and all registered outputs.
  always_ff @(posedge vfpconfig_aclk or negedge vfpconfig_aresetn) begin
    if (!vfpconfig_aresetn) begin
      state      <= S_IDLE;
      idx        <= '0;
      num_lat    <= '0;
      verify_lat <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= 2'b00;
      err_index  <= '0;
      awaddr     <= '0;
      awvalid    <= 1'b0;
      wdata      <= '0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      araddr     <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
    end else if (fail_now) begin
      // Abort: drop every valid/ready at once so no handshake is left open.
      error     <= 1'b1;
      err_code  <= fail_code;
      err_index <= idx;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b1;
      state     <= S_DONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            verify_lat <= verify_en;
            num_lat    <= num_entries;
            idx        <= '0;
            error      <= 1'b0;
            err_code   <= 2'b00;
            err_index  <= '0;
            busy       <= 1'b1;
            cnt        <= '0;
            if (num_entries == '0) begin
              state <= S_DONE;
            end else begin
              awaddr  <= row0_a;
              wdata   <= row0_d;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= S_WR;
            end
          end
        end
        S_WR: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready) wvalid <= 1'b0;
          if (aw_ok && w_ok) begin
            bready <= 1'b1;
            cnt    <= '0;
            state  <= S_WAIT_B;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_B: begin
          if (bvalid) begin
            bready <= 1'b0;
            cnt    <= '0;
            if (verify_lat) begin
              araddr  <= tbl_a[idx];
              arvalid <= 1'b1;
              state   <= S_RD;
            end else begin
              state <= S_NEXT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RD: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            cnt     <= '0;
            state   <= S_WAIT_R;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_R: begin
          if (rvalid) begin
            rready <= 1'b0;
            cnt    <= '0;
            state  <= S_NEXT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_NEXT: begin
          cnt <= '0;
          if ({1'b0, idx} == num_lat - 1'b1) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx     <= idx_nxt;
            awaddr  <= tbl_a[idx_nxt];
            wdata   <= tbl_d[idx_nxt];
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            state   <= S_WR;
          end
        end
        S_DONE: begin
          // Entered with done already high after entries ran; an empty
          // sequence arrives here with done low and raises it first.
          if (!done) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            done  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vfp_config_sequencer.sv
// Testbench for vfp_config_sequencer: behavioural AXI4-Lite slave with
// random delays and fault injection, reference model of the expected
// transaction list and outcome, scoreboard and final report.
module tb_vfp_config_sequencer;

  localparam int AW      = 8;
  localparam int DW      = 32;
  localparam int DEPTH   = 16;
  localparam int IW      = 4;
  localparam int TIMEOUT = 255;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 0, verify_en = 0, tbl_we = 0;
  logic [IW:0]   num_entries = '0;
  logic [IW-1:0] tbl_index = '0;
  logic [AW-1:0] tbl_addr = '0;
  logic [DW-1:0] tbl_data = '0;
  logic          busy, done, error;
  logic [1:0]    err_code;
  logic [IW-1:0] err_index;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot, dbg_state;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  vfp_config_sequencer dut (
    .vfpconfig_aclk(clk), .vfpconfig_aresetn(rst_n),
    .start(start), .verify_en(verify_en), .num_entries(num_entries),
    .tbl_we(tbl_we), .tbl_index(tbl_index), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .err_index(err_index),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference data ----------------
  logic [AW-1:0]    m_addr [DEPTH];
  logic [DW-1:0]    m_data [DEPTH];
  logic [AW+DW-1:0] exp_q[$];
  logic [AW-1:0]    exp_rd_q[$];
  logic             e_err;
  logic [1:0]       e_code;
  logic [IW-1:0]    e_idx;

  // ---------------- slave model state ----------------
  int               max_d = 0;
  int               bad_b_at = -1;
  int               bad_r_at = -1;
  bit               aw_stuck = 0;
  bit               aw_got, w_got, b_armed, r_armed;
  int               b_cnt, r_cnt, wr_num, rd_num;
  logic [1:0]       b_resp_pend;
  logic [AW-1:0]    got_addr, r_addr;
  logic [DW-1:0]    got_data;
  logic [DW-1:0]    slv_mem [256];
  logic [AW+DW-1:0] wr_log[$];
  logic [AW-1:0]    rd_log[$];
  int               awv_cycles, wv_cycles;
  bit               hs_aw, hs_w, hs_b, hs_ar, hs_r;
  bit               aw_pend, w_pend, ar_pend;

  task automatic slave_clear();
    aw_got = 0; w_got = 0; b_armed = 0; r_armed = 0;
    b_cnt = 0; r_cnt = 0; wr_num = 0; rd_num = 0;
    awv_cycles = 0; wv_cycles = 0;
    aw_pend = 0; w_pend = 0; ar_pend = 0;
    wr_log.delete(); rd_log.delete();
  endtask

  function automatic bit rnd_ready();
    return (max_d == 0) || ($urandom_range(0, 2) == 0);
  endfunction

  // Slave: observe handshakes mid-cycle, update its outputs just after each edge.
  initial begin
    awready = 0; wready = 0; arready = 0;
    bvalid = 0; bresp = 0; rvalid = 0; rresp = 0; rdata = '0;
    slave_clear();
    forever begin
      @(negedge clk);
      hs_aw = rst_n && awvalid && awready;
      hs_w  = rst_n && wvalid && wready;
      hs_b  = rst_n && bvalid && bready;
      hs_ar = rst_n && arvalid && arready;
      hs_r  = rst_n && rvalid && rready;
      if (rst_n) begin
        if (awvalid) awv_cycles++;
        if (wvalid) wv_cycles++;
        // A valid left waiting may only vanish on the abort/done cycle.
        if (aw_pend && !done) chk("aw_hold", 64'(awvalid), 64'd1);
        if (w_pend && !done) chk("w_hold", 64'(wvalid), 64'd1);
        if (ar_pend && !done) chk("ar_hold", 64'(arvalid), 64'd1);
        aw_pend = awvalid && !awready;
        w_pend  = wvalid && !wready;
        ar_pend = arvalid && !arready;
      end else begin
        aw_pend = 0; w_pend = 0; ar_pend = 0;
      end
      if (hs_aw) got_addr = awaddr;
      if (hs_w) begin
        got_data = wdata;
        chk("wstrb", 64'(wstrb), 64'hF);
      end
      if (hs_ar) begin
        r_addr = araddr;
        rd_log.push_back(araddr);
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
        awready = 0; wready = 0; arready = 0;
        bvalid = 0; bresp = 0; rvalid = 0; rresp = 0;
        aw_got = 0; w_got = 0; b_armed = 0; r_armed = 0;
        continue;
      end
      if (hs_b) begin bvalid = 0; bresp = 2'b00; end
      if (b_armed) begin
        if (b_cnt == 0) begin bvalid = 1; bresp = b_resp_pend; b_armed = 0; end
        else b_cnt--;
      end
      if (hs_aw) aw_got = 1;
      if (hs_w) w_got = 1;
      if (aw_got && w_got) begin
        wr_log.push_back({got_addr, got_data});
        slv_mem[got_addr] = got_data;
        b_resp_pend = (wr_num == bad_b_at) ? 2'b10 : 2'b00;
        wr_num++;
        aw_got = 0; w_got = 0;
        b_armed = 1; b_cnt = $urandom_range(0, max_d);
      end
      if (hs_r) begin rvalid = 0; rresp = 2'b00; end
      if (r_armed) begin
        if (r_cnt == 0) begin
          rvalid = 1; rresp = 2'b00;
          rdata = slv_mem[r_addr] ^ ((rd_num == bad_r_at) ? 32'h1 : 32'h0);
          rd_num++; r_armed = 0;
        end else r_cnt--;
      end
      if (hs_ar) begin r_armed = 1; r_cnt = $urandom_range(0, max_d); end
      awready = !aw_stuck && rnd_ready();
      wready  = rnd_ready();
      arready = rnd_ready();
    end
  end

  // Reference model: what a run over the table must produce.
  task automatic build_exp(input int n, input bit ver);
    exp_q.delete(); exp_rd_q.delete();
    e_err = 0; e_code = 2'b00; e_idx = '0;
    for (int i = 0; i < n; i++) begin
      if (aw_stuck) begin e_err = 1; e_code = 2'b11; e_idx = IW'(i); break; end
      exp_q.push_back({m_addr[i], m_data[i]});
      if (i == bad_b_at) begin e_err = 1; e_code = 2'b01; e_idx = IW'(i); break; end
      if (ver) begin
        exp_rd_q.push_back(m_addr[i]);
        if (i == bad_r_at) begin e_err = 1; e_code = 2'b10; e_idx = IW'(i); break; end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    tbl_we = 1; tbl_index = IW'(i); tbl_addr = a; tbl_data = d;
    m_addr[i] = a; m_data[i] = d;
    @(posedge clk); #1;
    tbl_we = 0;
  endtask

  task automatic run_seq(input int n, input bit ver, input int exp_cyc,
                         input bit wr0, input logic [AW-1:0] na, input logic [DW-1:0] nd);
    int cyc;
    slave_clear();
    @(posedge clk); #1;
    start = 1; verify_en = ver; num_entries = (IW+1)'(n);
    if (wr0) begin
      tbl_we = 1; tbl_index = '0; tbl_addr = na; tbl_data = nd;
      m_addr[0] = na; m_data[0] = nd;
    end
    build_exp(n, ver);
    @(posedge clk); #1;
    start = 0; tbl_we = 0;
    cyc = 1;
    @(negedge clk);
    chk("busy_c1", 64'(busy), 64'd1);
    if (n > 0) begin
      chk("awvalid_c1", 64'(awvalid), 64'd1);
      chk("wvalid_c1", 64'(wvalid), 64'd1);
    end
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", 64'(done), 64'd1);
    if (exp_cyc > 0) chk("done_cycle", 64'(cyc), 64'(exp_cyc));
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("error", 64'(error), 64'(e_err));
    chk("err_code", 64'(err_code), 64'(e_code));
    if (e_err) chk("err_index", 64'(err_index), 64'(e_idx));
    chk("bus_idle_at_done", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    chk("wr_count", 64'(wr_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
      chk($sformatf("wr[%0d]", i), 64'(wr_log[i]), 64'(exp_q[i]));
    chk("rd_count", 64'(rd_log.size()), 64'(exp_rd_q.size()));
    for (int i = 0; i < exp_rd_q.size() && i < rd_log.size(); i++)
      chk($sformatf("rd[%0d]", i), 64'(rd_log[i]), 64'(exp_rd_q[i]));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
    chk({tag, "_err_code"}, 64'(err_code), 64'd0);
    chk({tag, "_err_index"}, 64'(err_index), 64'd0);
    chk({tag, "_valids"}, 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    chk({tag, "_awaddr"}, 64'(awaddr), 64'd0);
    chk({tag, "_wdata"}, 64'(wdata), 64'd0);
    chk({tag, "_araddr"}, 64'(araddr), 64'd0);
  endtask

  task automatic rand_table();
    for (int i = 0; i < DEPTH; i++)
      load(i, AW'($urandom_range(0, 255)), $urandom());
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    check_idle_outputs("reset");

    // Three-entry table, zero-wait slave, write-only then verified.
    load(0, 8'h00, 32'h0000_0001);
    load(1, 8'h04, 32'h0000_00A5);
    load(2, 8'h08, 32'h0000_FFFF);
    run_seq(3, 0, 3 * 4 + 1, 0, '0, '0);
    run_seq(3, 1, 3 * 7 + 1, 0, '0, '0);

    // Read-back mismatch on entry 1.
    bad_r_at = 1;
    run_seq(3, 1, -1, 0, '0, '0);
    bad_r_at = -1;

    // Error response on the first write.
    bad_b_at = 0;
    run_seq(3, 0, -1, 0, '0, '0);
    bad_b_at = -1;

    // Empty sequence.
    run_seq(0, 0, 2, 0, '0, '0);

    // AW never accepted: W completes once, AW waits out the timeout.
    aw_stuck = 1;
    run_seq(1, 0, TIMEOUT + 1, 0, '0, '0);
    chk("tmo_awvalid_cycles", 64'(awv_cycles), 64'(TIMEOUT));
    chk("tmo_wvalid_cycles", 64'(wv_cycles), 64'd1);
    aw_stuck = 0;

    // Table write in the start cycle feeds entry 0.
    run_seq(1, 1, 8, 1, 8'h40, 32'hDEAD_BEEF);

    // Randomized delays over random tables.
    max_d = 5;
    for (int k = 0; k < 3; k++) begin
      rand_table();
      run_seq((k == 0) ? 16 : $urandom_range(1, 16), 1'($urandom_range(0, 1)), -1, 0, '0, '0);
    end

    // Asynchronous reset in the middle of a verified 16-entry run.
    slave_clear();
    @(posedge clk); #1;
    start = 1; verify_en = 1; num_entries = 5'd16;
    @(posedge clk); #1;
    start = 0;
    repeat ($urandom_range(20, 60)) @(posedge clk);
    #3;
    chk("busy_before_reset", 64'(busy), 64'd1);
    rst_n = 0;
    #1;
    check_idle_outputs("async_reset");
    repeat (3) @(negedge clk);
    #2 rst_n = 1;
    run_seq(16, 1, -1, 0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global bound on run length.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
